// File: rtl/plru_tree_array_if.sv
// Event/query bundle between a cache controller and plru_tree_array.
// Defining PLRU_WAY_LOCK_EN adds the global lock_mask signal.
interface plru_tree_array_if #(
  parameter int SETS = 16,
  parameter int WAYS = 4
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic             acc_valid;
  logic [IDX_W-1:0] acc_index;
  logic [WAY_W-1:0] acc_way;
  logic             acc_fill;
  logic             inv_valid;
  logic [IDX_W-1:0] inv_index;
  logic [WAY_W-1:0] inv_way;
  logic             qry_valid;
  logic [IDX_W-1:0] qry_index;
  logic             victim_valid;
  logic [WAY_W-1:0] victim_way;
  logic             victim_inv;
  logic             flush_req;
  logic             flush_busy;
`ifdef PLRU_WAY_LOCK_EN
  logic [WAYS-1:0]  lock_mask;
`endif

  modport master (
`ifdef PLRU_WAY_LOCK_EN
    output lock_mask,
`endif
    output acc_valid, acc_index, acc_way, acc_fill,
    output inv_valid, inv_index, inv_way,
    output qry_valid, qry_index, flush_req,
    input  victim_valid, victim_way, victim_inv, flush_busy
  );

  modport slave (
`ifdef PLRU_WAY_LOCK_EN
    input  lock_mask,
`endif
    input  acc_valid, acc_index, acc_way, acc_fill,
    input  inv_valid, inv_index, inv_way,
    input  qry_valid, qry_index, flush_req,
    output victim_valid, victim_way, victim_inv, flush_busy
  );
endinterface

// File: rtl/plru_tree_array.sv
// Tree-PLRU replacement engine with per-way valid bits, write-first victim query
// and a one-set-per-cycle flush sweep. Optional way locking: PLRU_WAY_LOCK_EN.
module plru_tree_array #(
  parameter int SETS = 16,
  parameter int WAYS = 4
) (
  input logic clk,
  input logic rst_n,
  plru_tree_array_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [WAYS-2:0]  tree_q [SETS];
  logic [WAYS-2:0]  tree_d [SETS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  valid_d [SETS];
  logic             victim_valid_q, victim_valid_d;
  logic [WAY_W-1:0] victim_way_q, victim_way_d;
  logic             victim_inv_q, victim_inv_d;
  logic             flush_busy_q, flush_busy_d;
  logic [WAY_W+1:0] pick_res;
  logic [WAYS-1:0]  elig;

`ifdef PLRU_WAY_LOCK_EN
  assign elig = ~bus.lock_mask;
`else
  assign elig = '1;
`endif

  // Point every node on the path to the touched way at the opposite subtree.
  function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] tree,
                                             input logic [WAY_W-1:0] way);
    logic [WAYS-2:0]  t;
    logic [WAY_W-1:0] wv;
    logic             b;
    int               n;
    t  = tree;
    wv = way;
    n  = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = wv[WAY_W-1];
      wv = wv << 1;
      t[n[WAY_W-1:0]] = ~b;
      n = 2 * n + 1 + (b ? 1 : 0);
    end
    return t;
  endfunction

  // Result is {found, invalid_pick, way}.
  function automatic logic [WAY_W+1:0] pick(input logic [WAYS-2:0] tree,
                                            input logic [WAYS-1:0] valid,
                                            input logic [WAYS-1:0] el);
    logic [WAYS-1:0]  cand;
    logic             found;
    logic [WAY_W-1:0] way;
    logic             left_ok, right_ok, b;
    int               n, p;
    cand  = ~valid & el;
    found = 1'b0;
    way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (cand[w[WAY_W-1:0]] && !found) begin
        found = 1'b1;
        way   = w[WAY_W-1:0];
      end
    end
    if (found) return {1'b1, 1'b1, way};
    if (el == '0) return '0;
    n = 0;
    p = 0;
    for (int l = 0; l < WAY_W; l++) begin
      left_ok  = 1'b0;
      right_ok = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        if ((w >> (WAY_W - 1 - l)) == 2 * p)     left_ok  = left_ok  | el[w[WAY_W-1:0]];
        if ((w >> (WAY_W - 1 - l)) == 2 * p + 1) right_ok = right_ok | el[w[WAY_W-1:0]];
      end
      b = tree[n[WAY_W-1:0]];
      if (b && !right_ok)      b = 1'b0;
      else if (!b && !left_ok) b = 1'b1;
      p = 2 * p + (b ? 1 : 0);
      n = 2 * n + 1 + (b ? 1 : 0);
    end
    return {1'b1, 1'b0, p[WAY_W-1:0]};
  endfunction

  // The query looks at the queried set's next state so same-cycle updates are visible.
  always_comb begin
    tree_d         = tree_q;
    valid_d        = valid_q;
    state_d        = state_q;
    cnt_d          = cnt_q;
    victim_valid_d = 1'b0;
    victim_way_d   = victim_way_q;
    victim_inv_d   = victim_inv_q;
    pick_res       = '0;
    if (state_q == IDLE) begin
      if (bus.acc_valid) begin
        tree_d[bus.acc_index] = touch(tree_q[bus.acc_index], bus.acc_way);
        if (bus.acc_fill) valid_d[bus.acc_index][bus.acc_way] = 1'b1;
      end
      if (bus.inv_valid) valid_d[bus.inv_index][bus.inv_way] = 1'b0;
      if (bus.flush_req) begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
      if (bus.qry_valid) begin
        pick_res       = pick(tree_d[bus.qry_index], valid_d[bus.qry_index], elig);
        victim_valid_d = pick_res[WAY_W+1];
        if (pick_res[WAY_W+1]) begin
          victim_inv_d = pick_res[WAY_W];
          victim_way_d = pick_res[WAY_W-1:0];
        end
      end
    end else begin
      tree_d[cnt_q]  = '0;
      valid_d[cnt_q] = '0;
      cnt_d          = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(SETS - 1)) state_d = IDLE;
    end
    flush_busy_d = (state_d == SWEEP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tree_q         <= '{default: '0};
      valid_q        <= '{default: '0};
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      victim_inv_q   <= 1'b0;
      flush_busy_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tree_q         <= tree_d;
      valid_q        <= valid_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
      victim_inv_q   <= victim_inv_d;
      flush_busy_q   <= flush_busy_d;
    end
  end

  assign bus.victim_valid = victim_valid_q;
  assign bus.victim_way   = victim_way_q;
  assign bus.victim_inv   = victim_inv_q;
  assign bus.flush_busy   = flush_busy_q;
endmodule

// File: tb/tb_plru_tree_array.sv
// Randomised and directed bench for plru_tree_array against a range-halving PLRU model.
module tb_plru_tree_array;
  localparam int SETS  = 16;
  localparam int WAYS  = 4;
  localparam int WAY_W = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  plru_tree_array_if #(.SETS(SETS), .WAYS(WAYS)) bus ();
  plru_tree_array #(.SETS(SETS), .WAYS(WAYS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  int mtree  [SETS][WAYS-1];
  bit mvalid [SETS][WAYS];
  bit msweep;
  int mcnt;
  int exp_vv, exp_way, exp_inv;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit lockedWay(input int w);
`ifdef PLRU_WAY_LOCK_EN
    return bus.lock_mask[w];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int eligCount(input int lo, input int hi);
    int c = 0;
    for (int w = lo; w < hi; w++) if (!lockedWay(w)) c++;
    return c;
  endfunction

  // Victim for set s from the model state: invalid eligible first, else range walk.
  task automatic modelQuery(input int s);
    int lo, hi, mid, node;
    bit goright;
    for (int w = 0; w < WAYS; w++) begin
      if (!mvalid[s][w] && !lockedWay(w)) begin
        exp_vv = 1; exp_way = w; exp_inv = 1;
        return;
      end
    end
    if (eligCount(0, WAYS) == 0) begin
      exp_vv = 0;
      return;
    end
    lo = 0; hi = WAYS; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      goright = (mtree[s][node] == 1 && eligCount(mid, hi) > 0) || eligCount(lo, mid) == 0;
      if (goright) begin lo = mid; node = 2 * node + 2; end
      else begin hi = mid; node = 2 * node + 1; end
    end
    exp_vv = 1; exp_way = lo; exp_inv = 0;
  endtask

  task automatic modelAccess(input int s, input int way);
    int lo = 0, hi = WAYS, mid, node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (way < mid) begin mtree[s][node] = 1; hi = mid; node = 2 * node + 1; end
      else begin mtree[s][node] = 0; lo = mid; node = 2 * node + 2; end
    end
  endtask

  task automatic modelClearSet(input int s);
    for (int n = 0; n < WAYS - 1; n++) mtree[s][n] = 0;
    for (int w = 0; w < WAYS; w++) mvalid[s][w] = 0;
  endtask

  task automatic modelStep();
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) modelClearSet(s);
      msweep = 0; mcnt = 0; exp_vv = 0; exp_way = 0; exp_inv = 0;
    end else if (!msweep) begin
      if (bus.acc_valid) begin
        modelAccess(int'(bus.acc_index), int'(bus.acc_way));
        if (bus.acc_fill) mvalid[bus.acc_index][bus.acc_way] = 1;
      end
      if (bus.inv_valid) mvalid[bus.inv_index][bus.inv_way] = 0;
      if (bus.flush_req) begin msweep = 1; mcnt = 0; end
      if (bus.qry_valid) modelQuery(int'(bus.qry_index));
      else exp_vv = 0;
    end else begin
      exp_vv = 0;
      modelClearSet(mcnt);
      mcnt++;
      if (mcnt == SETS) msweep = 0;
    end
  endtask

  // One clock: update model from current inputs, clock, then compare outputs.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("victim_valid", bus.victim_valid, exp_vv);
    checkOutput("victim_way", bus.victim_way, exp_way);
    checkOutput("victim_inv", bus.victim_inv, exp_inv);
    checkOutput("flush_busy", bus.flush_busy, msweep);
  endtask

  task automatic idleInputs();
    bus.acc_valid = 0; bus.acc_index = '0; bus.acc_way = '0; bus.acc_fill = 0;
    bus.inv_valid = 0; bus.inv_index = '0; bus.inv_way = '0;
    bus.qry_valid = 0; bus.qry_index = '0; bus.flush_req = 0;
`ifdef PLRU_WAY_LOCK_EN
    bus.lock_mask = '0;
`endif
  endtask

  task automatic fillSet(input int s);
    for (int w = 0; w < WAYS; w++) begin
      idleInputs();
      bus.acc_valid = 1; bus.acc_fill = 1; bus.acc_index = s[3:0]; bus.acc_way = w[WAY_W-1:0];
      applyStimulus();
    end
    idleInputs();
  endtask

  task automatic querySet(input int s);
    idleInputs();
    bus.qry_valid = 1; bus.qry_index = s[3:0];
    applyStimulus();
    idleInputs();
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 0;
    applyStimulus();
    applyStimulus();
    rst_n = 1;
  endtask

  initial begin
    int busy_cycles;
    rst_n = 0;
    idleInputs();
    doReset();
    checkOutput("reset_vv", bus.victim_valid, 0);
    checkOutput("reset_busy", bus.flush_busy, 0);

    querySet(3);
    checkOutput("q3_vv", bus.victim_valid, 1);
    checkOutput("q3_way", bus.victim_way, 0);
    checkOutput("q3_inv", bus.victim_inv, 1);

    fillSet(5);
    querySet(5);
    checkOutput("s5_way", bus.victim_way, 0);
    checkOutput("s5_inv", bus.victim_inv, 0);
    bus.acc_valid = 1; bus.acc_index = 4'd5; bus.acc_way = 2'd0;
    applyStimulus();
    querySet(5);
    checkOutput("s5_touch_way", bus.victim_way, 2);

    fillSet(7);
    bus.inv_valid = 1; bus.inv_index = 4'd7; bus.inv_way = 2'd2;
    bus.qry_valid = 1; bus.qry_index = 4'd7;
    applyStimulus();
    idleInputs();
    checkOutput("s7_bypass_way", bus.victim_way, 2);
    checkOutput("s7_bypass_inv", bus.victim_inv, 1);

    fillSet(9);
    bus.acc_valid = 1; bus.acc_index = 4'd9; bus.acc_way = 2'd1; bus.acc_fill = 1;
    bus.inv_valid = 1; bus.inv_index = 4'd9; bus.inv_way = 2'd1;
    applyStimulus();
    querySet(9);
    checkOutput("s9_way", bus.victim_way, 1);
    checkOutput("s9_inv", bus.victim_inv, 1);

    for (int s = 0; s < SETS; s++) fillSet(s);
    bus.flush_req = 1;
    applyStimulus();
    idleInputs();
    busy_cycles = 0;
    for (int c = 0; c < 40 && bus.flush_busy; c++) begin
      busy_cycles++;
      idleInputs();
      bus.acc_valid = 1; bus.acc_fill = 1; bus.acc_index = 4'd15; bus.acc_way = 2'd0;
      bus.qry_valid = 1; bus.qry_index = 4'd15;
      applyStimulus();
    end
    idleInputs();
    checkOutput("flush_busy_len", busy_cycles, SETS);
    querySet(15);
    checkOutput("post_flush_way", bus.victim_way, 0);
    checkOutput("post_flush_inv", bus.victim_inv, 1);

    for (int s = 0; s < SETS; s++) fillSet(s);
    bus.flush_req = 1;
    applyStimulus();
    idleInputs();
    for (int c = 0; c < 6; c++) applyStimulus();
    rst_n = 0;
    applyStimulus();
    checkOutput("reset_in_sweep_busy", bus.flush_busy, 0);
    rst_n = 1;
    querySet(12);
    checkOutput("reset_in_sweep_inv", bus.victim_inv, 1);

`ifdef PLRU_WAY_LOCK_EN
    doReset();
    fillSet(5);
    bus.acc_valid = 1; bus.acc_index = 4'd5; bus.acc_way = 2'd0;
    applyStimulus();
    idleInputs();
    bus.lock_mask = 4'b0001; bus.qry_valid = 1; bus.qry_index = 4'd5;
    applyStimulus();
    checkOutput("lock1_way", bus.victim_way, 2);
    bus.lock_mask = 4'b1111;
    applyStimulus();
    checkOutput("lock_all_vv", bus.victim_valid, 0);
    idleInputs();
`endif

    for (int c = 0; c < 4000; c++) begin
      idleInputs();
      rst_n = ($urandom_range(0, 499) != 0);
      bus.acc_valid = $urandom_range(0, 1);
      bus.acc_index = 4'($urandom_range(0, SETS - 1));
      bus.acc_way   = 2'($urandom_range(0, WAYS - 1));
      bus.acc_fill  = ($urandom_range(0, 3) != 0);
      bus.inv_valid = ($urandom_range(0, 3) == 0);
      bus.inv_index = ($urandom_range(0, 1) != 0) ? bus.acc_index : 4'($urandom_range(0, SETS - 1));
      bus.inv_way   = 2'($urandom_range(0, WAYS - 1));
      bus.qry_valid = $urandom_range(0, 1);
      bus.qry_index = ($urandom_range(0, 1) != 0) ? bus.acc_index : 4'($urandom_range(0, SETS - 1));
      bus.flush_req = ($urandom_range(0, 199) == 0);
`ifdef PLRU_WAY_LOCK_EN
      if ($urandom_range(0, 3) == 0) bus.lock_mask = 4'($urandom_range(0, 15));
`endif
      applyStimulus();
    end
    rst_n = 1;
    idleInputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
